// File: rtl/seg_scan_mux.sv
// Eight-digit seven-segment scan controller: walks the nibbles of a 32-bit value
// onto the decoder bus and drives active-low anodes/DP with a per-slot dead time.
module seg_scan_mux #(
    parameter int unsigned CLK_DIV = 100000,
    parameter int unsigned GUARD   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] VALUE,
    input  logic        LOAD,
    input  logic [7:0]  DP_MASK,
    input  logic        BLANK_LZ,
    output logic [3:0]  D,
    output logic [7:0]  AN,
    output logic        DP,
    output logic        FRAME
);

    localparam int CW = 24;

    typedef enum logic {S_GUARD, S_SHOW} slot_state_t;

    slot_state_t r_state, w_state_nxt;

    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic          r_run;

    logic [31:0]   r_pend_val, r_disp_val, w_dval_nxt;
    logic [7:0]    r_pend_dp,  r_disp_dp,  w_ddp_nxt;
    logic          r_pend_lz,  r_disp_lz,  w_dlz_nxt;

    logic [3:0]    r_d,  w_d_nxt;
    logic [7:0]    r_an, w_an_nxt;
    logic          r_dp, w_dp_nxt;
    logic          r_frame, w_frame_nxt;

    logic          w_wrap;
    logic          w_boundary;
    logic [7:0]    w_blank;

    // Outputs are registered from next-state values so they line up with the
    // cnt/idx of the cycle they are visible in.
    assign D     = r_d;
    assign AN    = r_an;
    assign DP    = r_dp;
    assign FRAME = r_frame;

    // r_run is clear for the first edge after reset, which opens the digit-0 slot
    // without advancing the counter.
    always_comb begin
        w_wrap    = (r_cnt == CW'(CLK_DIV - 1));
        w_cnt_nxt = r_cnt;
        w_idx_nxt = r_idx;
        if (!r_run) begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
        end else if (w_wrap) begin
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + 3'd1;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    assign w_boundary = !r_run || (w_wrap && (r_idx == 3'd7));

    // Display registers only move at a frame boundary; the old pending contents
    // win if a LOAD lands on that same edge.
    assign w_dval_nxt = w_boundary ? r_pend_val : r_disp_val;
    assign w_ddp_nxt  = w_boundary ? r_pend_dp  : r_disp_dp;
    assign w_dlz_nxt  = w_boundary ? r_pend_lz  : r_disp_lz;

    assign w_blank[0] = 1'b0;
    for (genvar gi = 1; gi < 8; gi++) begin : g_blank
        assign w_blank[gi] = w_dlz_nxt && (w_dval_nxt[31:4*gi] == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_GUARD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = 8'hFF;
        w_dp_nxt    = 1'b1;
        w_d_nxt     = r_d;
        w_frame_nxt = (w_cnt_nxt == '0) && (w_idx_nxt == 3'd0);

        case (r_state)
            S_GUARD: if (w_cnt_nxt >= CW'(GUARD)) w_state_nxt = S_SHOW;
            S_SHOW:  if (w_cnt_nxt == '0)         w_state_nxt = S_GUARD;
            default: w_state_nxt = S_GUARD;
        endcase

        if (w_state_nxt == S_SHOW) begin
            w_dp_nxt = ~w_ddp_nxt[w_idx_nxt];
            if (!w_blank[w_idx_nxt])
                w_an_nxt = ~(8'h01 << w_idx_nxt);
        end

        if (w_cnt_nxt == '0)
            w_d_nxt = w_dval_nxt[{w_idx_nxt, 2'b00} +: 4];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_run      <= 1'b0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend_lz  <= 1'b0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_disp_lz  <= 1'b0;
            r_d        <= 4'h0;
            r_an       <= 8'hFF;
            r_dp       <= 1'b1;
            r_frame    <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_run      <= 1'b1;
            r_disp_val <= w_dval_nxt;
            r_disp_dp  <= w_ddp_nxt;
            r_disp_lz  <= w_dlz_nxt;
            if (LOAD) begin
                r_pend_val <= VALUE;
                r_pend_dp  <= DP_MASK;
                r_pend_lz  <= BLANK_LZ;
            end
            r_d        <= w_d_nxt;
            r_an       <= w_an_nxt;
            r_dp       <= w_dp_nxt;
            r_frame    <= w_frame_nxt;
        end
    end

endmodule
